// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption: one shared 128-bit state register stepped through ADDK, nine inverse
// rounds and a final round. Define AES_INV_ABORT_EN to add the abort input.
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
`ifdef AES_INV_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam logic [3:0] NrL = 4'(NR);

    typedef enum logic [2:0] {
        StIdle,
        StAddk,
        StRound,
        StFinal,
        StDone
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  state_reg_q, state_reg_d;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            t[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        end
        t = t ^ 8'h05;
        return gf_inv(t);
    endfunction

    // ------------------------------------------------------------------
    // Byte n of the block is bits [127-8n -: 8]; n = 4*column + row.
    // ------------------------------------------------------------------
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127 - 8 * n -: 8] = inv_sbox(s[127 - 8 * n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                   gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                   gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                   gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                   gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Shared round datapath
    // ------------------------------------------------------------------
    logic [127:0] isr, isb, ark, imc;

    assign isr = inv_shift_rows(state_reg_q);
    assign isb = inv_sub_bytes(isr);
    assign ark = isb ^ round_key;
    assign imc = inv_mix_columns(ark);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            rnd_q       <= 4'd0;
            state_reg_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_reg_q <= state_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_reg_d = state_reg_q;
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_reg_d = data_in;
                    rnd_d       = NrL;
                    fsm_d       = StAddk;
                end
            end
            StAddk: begin
                state_reg_d = state_reg_q ^ round_key;
                rnd_d       = NrL - 4'd1;
                fsm_d       = StRound;
            end
            StRound: begin
                state_reg_d = imc;
                // Exit at 1 so the counter never wraps through 0.
                if (rnd_q == 4'd1) begin
                    fsm_d = StFinal;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            StFinal: begin
                state_reg_d = ark;
                fsm_d       = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
`ifdef AES_INV_ABORT_EN
        // Abort wins over round progress and the output handshake; the block contents are kept.
        if (abort && (fsm_q != StIdle)) begin
            fsm_d       = StIdle;
            rnd_d       = 4'd0;
            state_reg_d = state_reg_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = 4'd0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StAddk:  rk_idx = NrL;
            StRound: rk_idx = rnd_q;
            StFinal: rk_idx = 4'd0;
            StDone:  out_valid = 1'b1;
            default: rk_idx = 4'd0;
        endcase
    end

    assign data_out = state_reg_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl: key RAM built from a forward key expansion, expected
// plaintexts queued at accept and compared when the DUT hands them off.
module tb_aes_inv_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
`ifdef AES_INV_ABORT_EN
    logic         abort;
`endif

    aes_inv_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef AES_INV_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [127:0] rk_mem [0:10];
    assign round_key = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : 128'h0;

    logic [127:0] exp_q [$];

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vec [3];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- forward AES reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = mul(inv, a);
        end
        c = 8'h63;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
                   inv[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_mem[0];
        for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ rk_mem[r];
        return sub_shift(s) ^ rk_mem[10];
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    chk("plaintext", data_out, e);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        data_in  = ct;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("accept_timeout");
        else exp_q.push_back(pt);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0, t1, n;
        int acc [3];
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
`ifdef AES_INV_ABORT_EN
        abort     = 1'b0;
`endif
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        vec[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vec[0].pt = 128'h00112233445566778899aabbccddeeff;
        vec[1].pt = 128'h3243f6a8885a308d313198a2e0370734;
        vec[1].ct = aes_enc(vec[1].pt);
        vec[2].pt = {$urandom, $urandom, $urandom, $urandom};
        vec[2].ct = aes_enc(vec[2].pt);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vector: rk_idx walk and out_valid on the 11th edge after accept
        out_ready = 1'b1;
        send(vec[0].ct, vec[0].pt, t0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rk_seq", 128'(rk_idx), 128'((k <= 9) ? (10 - k) : 0));
            chk1("valid_seq", out_valid, (k == 11));
            chk1("busy_seq", busy, (k != 11) || 1'b1);
        end
        @(posedge clk);
        #1;

        // Back-pressure
        out_ready = 1'b0;
        send(vec[1].ct, vec[1].pt, t0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk1("bp_valid", out_valid, 1'b1);
            chk("bp_data", data_out, vec[1].pt);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_xfer_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("bp_after_valid", out_valid, 1'b0);
        chk1("bp_after_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Busy input: garbage on data_in with in_valid held
        out_ready = 1'b1;
        send(vec[0].ct, vec[0].pt, t0);
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk1("busy_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        send(vec[2].ct, vec[2].pt, t1);
        chk_int("busy_accept_gap", t1 - t0, 13);
        drain();

        // Back-to-back from the vector table
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vec[i].ct, vec[i].pt, acc[i]);
            if (i > 0) chk_int("b2b_gap", acc[i] - acc[i - 1], 13);
        end
        drain();

        // Reset mid-operation at rnd==5
        send(vec[1].ct, vec[1].pt, t0);
        n = 0;
        @(negedge clk);
        while (rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rk_idx != 4'd5) fail_now("rnd5_timeout");
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data_out", data_out, 128'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(vec[0].ct, vec[0].pt, t0);
        drain();

`ifdef AES_INV_ABORT_EN
        // Abort mid-round: high during cycle T+6, IDLE from T+7
        out_ready = 1'b1;
        send(vec[1].ct, vec[1].pt, t0);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk1("abort_busy_before", busy, 1'b1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        exp_q.delete();
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk1("abort_no_valid", seen, 1'b0);
        @(posedge clk);
        #1;

        // Abort while holding a result in DONE
        out_ready = 1'b0;
        send(vec[2].ct, vec[2].pt, t0);
        wait_valid();
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk1("abort_done_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk1("abort_done_dropped", out_valid, 1'b0);
        chk1("abort_done_ready", in_ready, 1'b1);
        chk("abort_done_keep", data_out, vec[2].pt);
        exp_q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vec[0].ct, vec[0].pt, t0);
        drain();
`endif

        chk_int("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
